// File: rtl/res_station_if.sv
// Issuer/CDB/ALU-facing signal bundle of the reservation station.
// slave = reservation station side, master = driver side (issuer, CDBs, control).
interface res_station_if #(
  parameter int ROB_ID_W = 4,
  parameter int XLEN     = 32,
  parameter int OP_W     = 6
);
  logic                rdy;
  logic                flush;
  logic [ROB_ID_W-1:0] dest_in;
  logic [OP_W-1:0]     op_in;
  logic [ROB_ID_W-1:0] qj_in;
  logic [ROB_ID_W-1:0] qk_in;
  logic [XLEN-1:0]     vj_in;
  logic [XLEN-1:0]     vk_in;
  logic [XLEN-1:0]     imm_in;
  logic [XLEN-1:0]     pc_in;
  logic [ROB_ID_W-1:0] alu_cdb_dest;
  logic [XLEN-1:0]     alu_cdb_val;
  logic [ROB_ID_W-1:0] lsb_cdb_dest;
  logic [XLEN-1:0]     lsb_cdb_val;
  logic                is_full;
  logic [ROB_ID_W-1:0] alu_dest;
  logic [OP_W-1:0]     alu_op;
  logic [XLEN-1:0]     alu_vj;
  logic [XLEN-1:0]     alu_vk;
  logic [XLEN-1:0]     alu_imm;
  logic [XLEN-1:0]     alu_pc;

  modport slave (
    input  rdy, flush, dest_in, op_in, qj_in, qk_in, vj_in, vk_in, imm_in, pc_in,
    input  alu_cdb_dest, alu_cdb_val, lsb_cdb_dest, lsb_cdb_val,
    output is_full, alu_dest, alu_op, alu_vj, alu_vk, alu_imm, alu_pc
  );

  modport master (
    output rdy, flush, dest_in, op_in, qj_in, qk_in, vj_in, vk_in, imm_in, pc_in,
    output alu_cdb_dest, alu_cdb_val, lsb_cdb_dest, lsb_cdb_val,
    input  is_full, alu_dest, alu_op, alu_vj, alu_vk, alu_imm, alu_pc
  );
endinterface

// File: rtl/res_station.sv
// Reservation station: holds non-memory ops until operands resolve, snoops ALU/LSB CDBs, dispatches one per cycle.
// Optional RS_AGE_PRIORITY_EN: oldest ready entry dispatches first instead of lowest index.
module res_station #(
  parameter int RS_SIZE  = 8,
  parameter int ROB_ID_W = 4,
  parameter int XLEN     = 32,
  parameter int OP_W     = 6
`ifdef RS_AGE_PRIORITY_EN
  , parameter int AGE_W  = 4
`endif
) (
  input  logic           clk,
  input  logic           rst,
  res_station_if.slave   bus
);
  localparam int IDX_W = $clog2(RS_SIZE);
  localparam int CNT_W = IDX_W + 1;

  logic                r_busy [RS_SIZE];
  logic [OP_W-1:0]     r_op   [RS_SIZE];
  logic [ROB_ID_W-1:0] r_qj   [RS_SIZE];
  logic [ROB_ID_W-1:0] r_qk   [RS_SIZE];
  logic [XLEN-1:0]     r_vj   [RS_SIZE];
  logic [XLEN-1:0]     r_vk   [RS_SIZE];
  logic [XLEN-1:0]     r_imm  [RS_SIZE];
  logic [XLEN-1:0]     r_pc   [RS_SIZE];
  logic [ROB_ID_W-1:0] r_dest [RS_SIZE];
`ifdef RS_AGE_PRIORITY_EN
  logic [AGE_W-1:0]    r_age  [RS_SIZE];
  logic [AGE_W-1:0]    w_best_age;
`endif

  logic [ROB_ID_W-1:0] r_alu_dest;
  logic [OP_W-1:0]     r_alu_op;
  logic [XLEN-1:0]     r_alu_vj, r_alu_vk, r_alu_imm, r_alu_pc;

  logic                w_has_free, w_alloc, w_disp_valid;
  logic [IDX_W-1:0]    w_free_idx, w_disp_idx;
  logic [CNT_W-1:0]    w_free_count;
  logic [ROB_ID_W-1:0] w_in_qj, w_in_qk;
  logic [XLEN-1:0]     w_in_vj, w_in_vk;

  // Operands whose producer broadcasts in the allocation cycle are captured as ready.
  always_comb begin
    w_in_qj = bus.qj_in;
    w_in_vj = bus.vj_in;
    w_in_qk = bus.qk_in;
    w_in_vk = bus.vk_in;
    if (bus.qj_in != '0 && bus.qj_in == bus.alu_cdb_dest) begin
      w_in_qj = '0;
      w_in_vj = bus.alu_cdb_val;
    end else if (bus.qj_in != '0 && bus.qj_in == bus.lsb_cdb_dest) begin
      w_in_qj = '0;
      w_in_vj = bus.lsb_cdb_val;
    end
    if (bus.qk_in != '0 && bus.qk_in == bus.alu_cdb_dest) begin
      w_in_qk = '0;
      w_in_vk = bus.alu_cdb_val;
    end else if (bus.qk_in != '0 && bus.qk_in == bus.lsb_cdb_dest) begin
      w_in_qk = '0;
      w_in_vk = bus.lsb_cdb_val;
    end
  end

  always_comb begin
    w_has_free   = 1'b0;
    w_free_idx   = '0;
    w_free_count = '0;
    w_disp_valid = 1'b0;
    w_disp_idx   = '0;
`ifdef RS_AGE_PRIORITY_EN
    w_best_age   = '0;
`endif
    for (int i = 0; i < RS_SIZE; i++) begin
      if (!r_busy[i]) begin
        w_free_count = w_free_count + CNT_W'(1);
        if (!w_has_free) begin
          w_has_free = 1'b1;
          w_free_idx = IDX_W'(i);
        end
      end
      if (r_busy[i] && r_qj[i] == '0 && r_qk[i] == '0) begin
`ifdef RS_AGE_PRIORITY_EN
        // strict > keeps the lower index on equal age
        if (!w_disp_valid || r_age[i] > w_best_age) begin
          w_disp_valid = 1'b1;
          w_disp_idx   = IDX_W'(i);
          w_best_age   = r_age[i];
        end
`else
        if (!w_disp_valid) begin
          w_disp_valid = 1'b1;
          w_disp_idx   = IDX_W'(i);
        end
`endif
      end
    end
  end

  // A write with no free entry breaks the issuer contract and is dropped.
  assign w_alloc = (bus.dest_in != '0) && w_has_free;

  genvar gi;
  generate
    for (gi = 0; gi < RS_SIZE; gi++) begin : g_entry
      logic w_alloc_here, w_disp_here;
      assign w_alloc_here = w_alloc && (w_free_idx == IDX_W'(gi));
      assign w_disp_here  = w_disp_valid && (w_disp_idx == IDX_W'(gi));

      always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
          r_busy[gi] <= 1'b0;
        end else if (bus.rdy) begin
          if (w_alloc_here) begin
            r_busy[gi] <= 1'b1;
            r_op[gi]   <= bus.op_in;
            r_qj[gi]   <= w_in_qj;
            r_qk[gi]   <= w_in_qk;
            r_vj[gi]   <= w_in_vj;
            r_vk[gi]   <= w_in_vk;
            r_imm[gi]  <= bus.imm_in;
            r_pc[gi]   <= bus.pc_in;
            r_dest[gi] <= bus.dest_in;
          end else if (r_busy[gi]) begin
            if (w_disp_here) r_busy[gi] <= 1'b0;
            if (r_qj[gi] != '0 && r_qj[gi] == bus.alu_cdb_dest) begin
              r_qj[gi] <= '0;
              r_vj[gi] <= bus.alu_cdb_val;
            end else if (r_qj[gi] != '0 && r_qj[gi] == bus.lsb_cdb_dest) begin
              r_qj[gi] <= '0;
              r_vj[gi] <= bus.lsb_cdb_val;
            end
            if (r_qk[gi] != '0 && r_qk[gi] == bus.alu_cdb_dest) begin
              r_qk[gi] <= '0;
              r_vk[gi] <= bus.alu_cdb_val;
            end else if (r_qk[gi] != '0 && r_qk[gi] == bus.lsb_cdb_dest) begin
              r_qk[gi] <= '0;
              r_vk[gi] <= bus.lsb_cdb_val;
            end
          end
        end
      end

`ifdef RS_AGE_PRIORITY_EN
      always_ff @(posedge clk) begin
        if (rst) begin
          r_age[gi] <= '0;
        end else if (bus.rdy && !bus.flush) begin
          if (w_alloc_here) r_age[gi] <= '0;
          else if (r_busy[gi] && r_age[gi] != '1) r_age[gi] <= r_age[gi] + AGE_W'(1);
        end
      end
`endif
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_dest <= '0;
      r_alu_op   <= '0;
      r_alu_vj   <= '0;
      r_alu_vk   <= '0;
      r_alu_imm  <= '0;
      r_alu_pc   <= '0;
    end else if (bus.flush) begin
      r_alu_dest <= '0;
    end else if (bus.rdy) begin
      if (w_disp_valid) begin
        r_alu_dest <= r_dest[w_disp_idx];
        r_alu_op   <= r_op[w_disp_idx];
        r_alu_vj   <= r_vj[w_disp_idx];
        r_alu_vk   <= r_vk[w_disp_idx];
        r_alu_imm  <= r_imm[w_disp_idx];
        r_alu_pc   <= r_pc[w_disp_idx];
      end else begin
        r_alu_dest <= '0;
      end
    end
  end

  // Two-free threshold leaves room for the op already latched in the issuer.
  assign bus.is_full  = (w_free_count < CNT_W'(2));
  assign bus.alu_dest = r_alu_dest;
  assign bus.alu_op   = r_alu_op;
  assign bus.alu_vj   = r_alu_vj;
  assign bus.alu_vk   = r_alu_vk;
  assign bus.alu_imm  = r_alu_imm;
  assign bus.alu_pc   = r_alu_pc;
endmodule

// File: tb/tb_res_station.sv
// Directed bench for res_station: latency, CDB snoop/capture, full flag, flush, rdy freeze, dispatch priority.
module tb_res_station;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  always #5 clk = ~clk;

  res_station_if #(.ROB_ID_W(4), .XLEN(32), .OP_W(6)) bus ();

  res_station #(.RS_SIZE(8), .ROB_ID_W(4), .XLEN(32), .OP_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.rdy = 1'b1; bus.flush = 1'b0;
    bus.dest_in = '0; bus.op_in = '0; bus.qj_in = '0; bus.qk_in = '0;
    bus.vj_in = '0; bus.vk_in = '0; bus.imm_in = '0; bus.pc_in = '0;
    bus.alu_cdb_dest = '0; bus.alu_cdb_val = '0;
    bus.lsb_cdb_dest = '0; bus.lsb_cdb_val = '0;
  endtask

  // Drives one issue for a cycle (on top of any CDB/flush already set), then returns to idle.
  task automatic issue(input logic [3:0] dest, input logic [3:0] qj, input logic [3:0] qk,
                       input logic [31:0] vj, input logic [31:0] vk);
    bus.dest_in = dest; bus.op_in = 6'h01; bus.qj_in = qj; bus.qk_in = qk;
    bus.vj_in = vj; bus.vk_in = vk; bus.imm_in = 32'h10; bus.pc_in = 32'h100;
    step();
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("reset_alu_dest", 32'(bus.alu_dest), 32'h0);
    chk("reset_alu_vj", bus.alu_vj, 32'h0);
    chk("reset_is_full", 32'(bus.is_full), 32'h0);

    // Ready op: dispatch two cycles after issue, then slot is empty again.
    issue(4'd3, 4'd0, 4'd0, 32'd5, 32'd7);
    chk("lat_n1_dest", 32'(bus.alu_dest), 32'h0);
    step();
    chk("lat_n2_dest", 32'(bus.alu_dest), 32'h3);
    chk("lat_n2_vj", bus.alu_vj, 32'd5);
    chk("lat_n2_vk", bus.alu_vk, 32'd7);
    chk("lat_n2_op", 32'(bus.alu_op), 32'h1);
    chk("lat_n2_imm", bus.alu_imm, 32'h10);
    chk("lat_n2_pc", bus.alu_pc, 32'h100);
    step();
    chk("lat_after_dest", 32'(bus.alu_dest), 32'h0);

    // Waiting on tag 2; ALU broadcast at cycle 3 -> dispatch visible at cycle 5.
    issue(4'd4, 4'd2, 4'd0, 32'd0, 32'd1);
    step(); step();
    bus.alu_cdb_dest = 4'd2; bus.alu_cdb_val = 32'h55;
    step();
    idle();
    chk("snoop_c4_dest", 32'(bus.alu_dest), 32'h0);
    step();
    chk("snoop_c5_dest", 32'(bus.alu_dest), 32'h4);
    chk("snoop_c5_vj", bus.alu_vj, 32'h55);
    chk("snoop_c5_vk", bus.alu_vk, 32'h1);

    // Same-cycle capture from both buses during allocation.
    bus.lsb_cdb_dest = 4'd5; bus.lsb_cdb_val = 32'd9;
    bus.alu_cdb_dest = 4'd2; bus.alu_cdb_val = 32'hAA;
    issue(4'd6, 4'd5, 4'd2, 32'd0, 32'd0);
    chk("capture_n1_dest", 32'(bus.alu_dest), 32'h0);
    step();
    chk("capture_n2_dest", 32'(bus.alu_dest), 32'h6);
    chk("capture_n2_vj", bus.alu_vj, 32'd9);
    chk("capture_n2_vk", bus.alu_vk, 32'hAA);
    step();

    // Fill 7 of 8 entries on tag 9: full threshold, then drain one per cycle in index order.
    for (int i = 1; i <= 7; i++) begin
      issue(4'(i), 4'd9, 4'd0, 32'd0, 32'(i));
      if (i == 6) chk("fill6_is_full", 32'(bus.is_full), 32'h0);
    end
    chk("fill7_is_full", 32'(bus.is_full), 32'h1);
    bus.alu_cdb_dest = 4'd9; bus.alu_cdb_val = 32'h99;
    step();
    idle();
    chk("drain_pre_dest", 32'(bus.alu_dest), 32'h0);
    chk("drain_pre_full", 32'(bus.is_full), 32'h1);
    for (int i = 1; i <= 7; i++) begin
      step();
      chk($sformatf("drain%0d_dest", i), 32'(bus.alu_dest), 32'(i));
      if (i == 1) begin
        chk("drain1_vj", bus.alu_vj, 32'h99);
        chk("drain1_full", 32'(bus.is_full), 32'h0);
      end
    end
    step();
    chk("drain_end_dest", 32'(bus.alu_dest), 32'h0);

    // Flush with a concurrent write: everything discarded, including a dispatch in flight.
    issue(4'd1, 4'd8, 4'd0, 32'd0, 32'd0);
    issue(4'd2, 4'd8, 4'd0, 32'd0, 32'd0);
    issue(4'd3, 4'd8, 4'd0, 32'd0, 32'd0);
    issue(4'd5, 4'd0, 4'd0, 32'd0, 32'd0);
    bus.flush = 1'b1;
    issue(4'd7, 4'd0, 4'd0, 32'd0, 32'd0);
    chk("flush_dest", 32'(bus.alu_dest), 32'h0);
    bus.alu_cdb_dest = 4'd8; bus.alu_cdb_val = 32'h1;
    step();
    idle();
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("flush_after%0d_dest", i), 32'(bus.alu_dest), 32'h0);
    end

    // rdy low freezes allocation-to-dispatch progress and holds alu outputs.
    issue(4'd2, 4'd0, 4'd0, 32'h21, 32'h22);
    bus.rdy = 1'b0;
    step(); step();
    chk("rdy0_frozen_dest", 32'(bus.alu_dest), 32'h0);
    bus.rdy = 1'b1;
    step();
    chk("rdy1_dispatch_dest", 32'(bus.alu_dest), 32'h2);
    bus.rdy = 1'b0;
    step();
    chk("rdy0_hold_dest", 32'(bus.alu_dest), 32'h2);
    chk("rdy0_hold_vj", bus.alu_vj, 32'h21);
    bus.rdy = 1'b1;
    step();
    chk("rdy1_idle_dest", 32'(bus.alu_dest), 32'h0);

    // Older waiter in entry1, younger waiter reallocated into entry0, both released together.
    issue(4'd3, 4'd0, 4'd0, 32'd0, 32'd0);
    issue(4'd2, 4'd9, 4'd0, 32'd0, 32'd0);
    chk("prio_x_dest", 32'(bus.alu_dest), 32'h3);
    issue(4'd4, 4'd9, 4'd0, 32'd0, 32'd0);
    bus.alu_cdb_dest = 4'd9; bus.alu_cdb_val = 32'h7;
    step();
    idle();
    chk("prio_pre_dest", 32'(bus.alu_dest), 32'h0);
    step();
`ifdef RS_AGE_PRIORITY_EN
    chk("prio_first_dest", 32'(bus.alu_dest), 32'h2);
    step();
    chk("prio_second_dest", 32'(bus.alu_dest), 32'h4);
`else
    chk("prio_first_dest", 32'(bus.alu_dest), 32'h4);
    step();
    chk("prio_second_dest", 32'(bus.alu_dest), 32'h2);
`endif
    step();
    chk("prio_end_dest", 32'(bus.alu_dest), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
